// File: rtl/cordic_pkg.sv
// Shared widths, constants and FSM state type for the CORDIC rotation sequencer.
package cordic_pkg;

  localparam int ANGLE_W = 32;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 34;

  localparam logic [ANGLE_W-1:0] ANGLE_90 = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    ITER
  } state_t;

  function automatic logic [DATA_W-1:0] sext(input logic [ANGLE_W-1:0] v);
    return {{(DATA_W-ANGLE_W){v[ANGLE_W-1]}}, v};
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One CORDIC rotation-mode micro-rotation: shift, add/subtract and angle update, purely combinational.
module cordic_microrot
  import cordic_pkg::*;
(
  input  logic signed [DATA_W-1:0]  x,
  input  logic signed [DATA_W-1:0]  y,
  input  logic        [ANGLE_W-1:0] z,
  input  logic        [ADDR_W-1:0]  i,
  input  logic        [ANGLE_W-1:0] atan,
  output logic signed [DATA_W-1:0]  x_next,
  output logic signed [DATA_W-1:0]  y_next,
  output logic        [ANGLE_W-1:0] z_next
);

  logic signed [DATA_W-1:0] x_sh;
  logic signed [DATA_W-1:0] y_sh;

  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    // A negative residual angle (d = -1) rotates clockwise.
    if (z[ANGLE_W-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan;
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC rotation-mode sequencer: load, prime the synchronous atan ROM, iterate, pulse Done.
// Optional CORDIC_QUADRANT_EN adds a +/-90 degree pre-rotation on Start for full-circle input.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 24
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [ANGLE_W-1:0] Xin,
  input  logic [ANGLE_W-1:0] Yin,
  input  logic [ANGLE_W-1:0] Zin,
  output logic               Busy,
  output logic               Done,
  output logic [DATA_W-1:0]  Xout,
  output logic [DATA_W-1:0]  Yout,
  output logic [ANGLE_W-1:0] Zout,
  output logic [ADDR_W-1:0]  Rom_Addr,
  input  logic [ANGLE_W-1:0] Rom_Data
);

  localparam logic [ADDR_W-1:0] LAST_ITER = ADDR_W'(ITERATIONS - 1);

  state_t                   state, state_next;
  logic        [ADDR_W-1:0] iter;
  logic signed [DATA_W-1:0] x_q, y_q;
  logic       [ANGLE_W-1:0] z_q;
  logic signed [DATA_W-1:0] x_nx, y_nx;
  logic       [ANGLE_W-1:0] z_nx;
  logic        [DATA_W-1:0] x_init, y_init;
  logic       [ANGLE_W-1:0] z_init;
  logic          [ADDR_W:0] addr_sum;
  logic        [ADDR_W-1:0] addr_next;
  logic                     last_iter;

  assign last_iter = (iter == LAST_ITER);

  // The address leads the iteration by two and parks on the final ROM entry.
  assign addr_sum  = {1'b0, iter} + (ADDR_W+1)'(2);
  assign addr_next = addr_sum[ADDR_W] ? '1 : addr_sum[ADDR_W-1:0];

  always_comb begin
    x_init = sext(Xin);
    y_init = sext(Yin);
    z_init = Zin;
`ifdef CORDIC_QUADRANT_EN
    case (Zin[ANGLE_W-1 -: 2])
      2'b01: begin
        x_init = -sext(Yin);
        y_init = sext(Xin);
        z_init = Zin - ANGLE_90;
      end
      2'b10: begin
        x_init = sext(Yin);
        y_init = -sext(Xin);
        z_init = Zin + ANGLE_90;
      end
      default: ;
    endcase
`endif
  end

  cordic_microrot u_microrot (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .i      (iter),
    .atan   (Rom_Data),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = PRIME;
      PRIME:   state_next = ITER;
      ITER:    if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    if (state != IDLE) Busy = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      iter     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      Xout     <= '0;
      Yout     <= '0;
      Zout     <= '0;
      Rom_Addr <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            x_q      <= x_init;
            y_q      <= y_init;
            z_q      <= z_init;
            iter     <= '0;
            Rom_Addr <= '0;
          end
        end
        PRIME: Rom_Addr <= ADDR_W'(1);
        ITER: begin
          x_q      <= x_nx;
          y_q      <= y_nx;
          z_q      <= z_nx;
          iter     <= iter + ADDR_W'(1);
          Rom_Addr <= addr_next;
          if (last_iter) begin
            Xout <= x_nx;
            Yout <= y_nx;
            Zout <= z_nx;
            Done <= 1'b1;
            iter <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl with a registered atan ROM model and vector table.
module tb_cordic_iter_ctrl;

  localparam int     ITERS = 24;
  localparam int     LAT   = ITERS + 1;
  localparam real    PI    = 3.14159265358979323846;
  localparam longint A     = 64'sh4000_0000;
  localparam longint A45   = 64'sh2D41_3CCC;
  // Residual angle after 24 steps can reach atan(2^-23), worth ~128 LSB at this scale.
  localparam longint TOL   = 160;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [31:0] Xin, Yin, Zin;
  logic        Busy, Done;
  logic [33:0] Xout, Yout;
  logic [31:0] Zout;
  logic [4:0]  Rom_Addr;
  logic [31:0] Rom_Data;

  logic [31:0] rom [32];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] xin;
    logic [31:0] yin;
    logic [31:0] zin;
    longint      exp_x;
    longint      exp_y;
  } vec_t;

  vec_t vecs[$];

  cordic_iter_ctrl #(.ITERATIONS(ITERS)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Xin      (Xin),
    .Yin      (Yin),
    .Zin      (Zin),
    .Busy     (Busy),
    .Done     (Done),
    .Xout     (Xout),
    .Yout     (Yout),
    .Zout     (Zout),
    .Rom_Addr (Rom_Addr),
    .Rom_Data (Rom_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) Rom_Data <= rom[Rom_Addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
    longint diff;
    n_checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic add_vec(input logic [31:0] xin, yin, zin, input longint ex, ey);
    vec_t v;
    v.xin = xin; v.yin = yin; v.zin = zin; v.exp_x = ex; v.exp_y = ey;
    vecs.push_back(v);
  endtask

  function automatic void model(input logic [31:0] xin, yin, zin,
                                output logic [33:0] xo, yo, output logic [31:0] zo);
    logic signed [33:0] x, y, xn, yn;
    logic        [31:0] z;
    x = {{2{xin[31]}}, xin};
    y = {{2{yin[31]}}, yin};
    z = zin;
`ifdef CORDIC_QUADRANT_EN
    if (zin[31:30] == 2'b01) begin
      x = -{{2{yin[31]}}, yin};
      y = {{2{xin[31]}}, xin};
      z = zin - 32'h4000_0000;
    end else if (zin[31:30] == 2'b10) begin
      x = {{2{yin[31]}}, yin};
      y = -{{2{xin[31]}}, xin};
      z = zin + 32'h4000_0000;
    end
`endif
    for (int i = 0; i < ITERS; i++) begin
      if (!z[31]) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - rom[i];
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + rom[i];
      end
      x = xn;
      y = yn;
    end
    xo = x;
    yo = y;
    zo = z;
  endfunction

  // Pulses Start for one edge, then watches cycles k = 0.. after the accepting edge until Done.
  task automatic run_op(input logic [31:0] xin, yin, zin, input bit trace, input bit noisy,
                        output int lat);
    lat = -1;
    @(negedge Clk);
    Xin = xin; Yin = yin; Zin = zin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge Clk);
      if (trace && k <= LAT) begin
        check($sformatf("rom_addr_k%0d", k), 64'(Rom_Addr), 64'(k));
        check($sformatf("busy_k%0d", k), 64'(Busy), 64'(k < LAT));
      end
      if (Done) begin
        lat = k;
        break;
      end
      if (noisy) begin
        Start = (k == 2 || k == 9);
        Xin   = 32'h7FFF_0000;
      end
    end
    Start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v);
    logic [33:0] mx, my;
    logic [31:0] mz;
    longint      zr;
    model(v.xin, v.yin, v.zin, mx, my, mz);
    check({tag, "_xout"}, 64'(Xout), 64'(mx));
    check({tag, "_yout"}, 64'(Yout), 64'(my));
    check({tag, "_zout"}, 64'(Zout), 64'(mz));
    check_near({tag, "_x_approx"}, longint'($signed(Xout)), v.exp_x, TOL);
    check_near({tag, "_y_approx"}, longint'($signed(Yout)), v.exp_y, TOL);
    zr = longint'($signed(Zout));
    check({tag, "_zout_small"}, 64'(zr < 256 && zr > -256), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     64'(Busy),     64'(0));
    check({tag, "_done"},     64'(Done),     64'(0));
    check({tag, "_xout"},     64'(Xout),     64'(0));
    check({tag, "_yout"},     64'(Yout),     64'(0));
    check({tag, "_zout"},     64'(Zout),     64'(0));
    check({tag, "_rom_addr"}, 64'(Rom_Addr), 64'(0));
  endtask

  initial begin
    int          lat, k1, k2;
    bit          seen;
    logic [33:0] x_hold;
    real         p;

    p = 1.0;
    for (int i = 0; i < 32; i++) begin
      rom[i] = 32'($rtoi($atan(p) / (2.0 * PI) * 4294967296.0 + 0.5));
      p = p / 2.0;
    end

    add_vec(32'h26DD_3B6A, 32'h0, 32'h2000_0000,  A45,  A45);
    add_vec(32'h26DD_3B6A, 32'h0, 32'h0000_0000,  A,    0);
    add_vec(32'h26DD_3B6A, 32'h0, 32'hE000_0000,  A45, -A45);
    add_vec(32'h26DD_3B6A, 32'h0, 32'h4000_0000,  0,    A);
    add_vec(32'h0, 32'h26DD_3B6A, 32'hE000_0000,  A45,  A45);
`ifdef CORDIC_QUADRANT_EN
    add_vec(32'h26DD_3B6A, 32'h0, 32'h6000_0000, -A45,  A45);
    add_vec(32'h26DD_3B6A, 32'h0, 32'hA000_0000, -A45, -A45);
`endif

    Start = 1'b0; Xin = '0; Yin = '0; Zin = '0;
    Rst_n = 1'b1;
    #2 Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Rst_n = 1'b1;

    foreach (vecs[n]) begin
      run_op(vecs[n].xin, vecs[n].yin, vecs[n].zin, n == 0, 1'b0, lat);
      check($sformatf("v%0d_done_latency", n), 64'(lat), 64'(LAT));
      check_result($sformatf("v%0d", n), vecs[n]);
      x_hold = Xout;
      @(negedge Clk);
      check($sformatf("v%0d_done_pulse", n), 64'(Done), 64'(0));
      repeat (3) @(negedge Clk);
      check($sformatf("v%0d_xout_hold", n), 64'(Xout), 64'(x_hold));
    end

    // Start pulses at t+3 and t+10 carry a different Xin and must be ignored.
    run_op(vecs[0].xin, vecs[0].yin, vecs[0].zin, 1'b1, 1'b1, lat);
    check("noisy_done_latency", 64'(lat), 64'(LAT));
    check_result("noisy", vecs[0]);
    @(negedge Clk);

    // Start held through the Done cycle gives back-to-back operation.
    k1 = -1; k2 = -1;
    @(negedge Clk);
    Xin = vecs[1].xin; Yin = vecs[1].yin; Zin = vecs[1].zin; Start = 1'b1;
    for (int k = 0; k < 80 && k2 < 0; k++) begin
      @(negedge Clk);
      if (k1 >= 0 && k == k1 + 1) Start = 1'b0;
      if (Done) begin
        if (k1 < 0) k1 = k;
        else        k2 = k;
      end
    end
    Start = 1'b0;
    check("b2b_first_done", 64'(k1), 64'(LAT));
    check("b2b_second_done", 64'(k2), 64'(LAT + ITERS + 2));
    check_result("b2b", vecs[1]);

    // Abort mid-run (during iteration 10) with a non-zero previous result on the outputs.
    @(negedge Clk);
    Xin = vecs[0].xin; Yin = vecs[0].yin; Zin = vecs[0].zin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (11) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'(0));

    run_op(vecs[2].xin, vecs[2].yin, vecs[2].zin, 1'b0, 1'b0, lat);
    check("post_abort_done_latency", 64'(lat), 64'(LAT));
    check_result("post_abort", vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
